// File: rtl/multicycle_control_fsm.sv
// Multicycle MIPS control FSM for the core subset: R-type, lw, sw, beq, bne,
// addi, andi, ori, slti and j. Drives every datapath mux select and write
// enable. A wait counter stretches the FETCH, MEM_READ and MEM_WRITE states
// to MEM_WAIT cycles each, so the memory latency can be configured.
// Outputs are Moore: they depend on state and counter only. The exceptions
// are BranchNe and the IMM_EXEC ALUSrcB choice, which read the opcode. The
// IR holds the opcode steady for the whole instruction.

module multicycle_control_fsm #(
  parameter int MEM_WAIT = 1,
  parameter int OPW      = 6
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [OPW-1:0] op_code,
  output logic           IorD,
  output logic           ALUSrcA,
  output logic [2:0]     ALUSrcB,
  output logic [1:0]     ALUOp,
  output logic [1:0]     PCSource,
  output logic           RegDst,
  output logic           MemtoReg,
  output logic           IRWrite,
  output logic           PCWrite,
  output logic           PCWriteCond,
  output logic           MemWrite,
  output logic           RegWrite,
  output logic           BranchNe,
  output logic           illegal_op,
  output logic [3:0]     state_o
);

  localparam logic [3:0] S_FETCH     = 4'd0;
  localparam logic [3:0] S_DECODE    = 4'd1;
  localparam logic [3:0] S_EXECUTE   = 4'd2;
  localparam logic [3:0] S_ALU_WB    = 4'd3;
  localparam logic [3:0] S_MEM_ADDR  = 4'd4;
  localparam logic [3:0] S_MEM_READ  = 4'd5;
  localparam logic [3:0] S_MEM_WB    = 4'd6;
  localparam logic [3:0] S_MEM_WRITE = 4'd7;
  localparam logic [3:0] S_BRANCH    = 4'd8;
  localparam logic [3:0] S_JUMP      = 4'd9;
  localparam logic [3:0] S_IMM_EXEC  = 4'd10;
  localparam logic [3:0] S_IMM_WB    = 4'd11;
  localparam logic [3:0] S_ILLEGAL   = 4'd12;

  localparam logic [OPW-1:0] OP_RTYPE = OPW'(6'b000000);
  localparam logic [OPW-1:0] OP_LW    = OPW'(6'b100011);
  localparam logic [OPW-1:0] OP_SW    = OPW'(6'b101011);
  localparam logic [OPW-1:0] OP_BEQ   = OPW'(6'b000100);
  localparam logic [OPW-1:0] OP_BNE   = OPW'(6'b000101);
  localparam logic [OPW-1:0] OP_J     = OPW'(6'b000010);
  localparam logic [OPW-1:0] OP_ADDI  = OPW'(6'b001000);
  localparam logic [OPW-1:0] OP_ANDI  = OPW'(6'b001100);
  localparam logic [OPW-1:0] OP_ORI   = OPW'(6'b001101);
  localparam logic [OPW-1:0] OP_SLTI  = OPW'(6'b001010);

  // Last counter value of a memory window; the counter runs 0..MEM_WAIT-1.
  localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT - 1);

  logic [3:0] state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       wait_done;

  // Unmasked enables; rst forces them low at the port boundary.
  logic ir_we, pc_we, pc_cond_we, mem_we, reg_we, illegal;

  assign wait_done = (cnt_q == WAIT_LAST);
  assign state_o   = state_q;

  // State and wait-counter registers; reset aborts any instruction at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and counter logic. The counter only moves inside wait states
  // and is cleared on the cycle that leaves them, so it enters every window at 0.
  always_comb begin
    state_d = state_q;
    cnt_d   = 4'd0;
    case (state_q)
      S_FETCH: begin
        if (wait_done) state_d = S_DECODE;
        else           cnt_d   = cnt_q + 4'd1;
      end
      S_DECODE: begin
        case (op_code)
          OP_RTYPE:                          state_d = S_EXECUTE;
          OP_LW, OP_SW:                      state_d = S_MEM_ADDR;
          OP_BEQ, OP_BNE:                    state_d = S_BRANCH;
          OP_J:                              state_d = S_JUMP;
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_d = S_IMM_EXEC;
          default:                           state_d = S_ILLEGAL;
        endcase
      end
      S_EXECUTE:  state_d = S_ALU_WB;
      S_ALU_WB:   state_d = S_FETCH;
      S_MEM_ADDR: state_d = (op_code == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ: begin
        if (wait_done) state_d = S_MEM_WB;
        else           cnt_d   = cnt_q + 4'd1;
      end
      S_MEM_WB:   state_d = S_FETCH;
      S_MEM_WRITE: begin
        if (wait_done) state_d = S_FETCH;
        else           cnt_d   = cnt_q + 4'd1;
      end
      S_BRANCH:   state_d = S_FETCH;
      S_JUMP:     state_d = S_FETCH;
      S_IMM_EXEC: state_d = S_IMM_WB;
      S_IMM_WB:   state_d = S_FETCH;
      S_ILLEGAL:  state_d = S_ILLEGAL;
      default:    state_d = S_FETCH;
    endcase
  end

  // Moore decode of the datapath selects and raw enables from the current state.
  always_comb begin
    IorD       = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 3'b000;
    ALUOp      = 2'b00;
    PCSource   = 2'b00;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    BranchNe   = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    pc_cond_we = 1'b0;
    mem_we     = 1'b0;
    reg_we     = 1'b0;
    illegal    = 1'b0;
    case (state_q)
      S_FETCH: begin
        ALUSrcB = 3'b001;
        // PC and IR load once, on the final cycle of the memory window.
        ir_we   = wait_done;
        pc_we   = wait_done;
      end
      S_DECODE: begin
        // Branch target computed speculatively while the opcode is decoded.
        ALUSrcB = 3'b011;
      end
      S_EXECUTE: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
      end
      S_ALU_WB: begin
        RegDst = 1'b1;
        reg_we = 1'b1;
      end
      S_MEM_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 3'b010;
      end
      S_MEM_READ: begin
        IorD = 1'b1;
      end
      S_MEM_WB: begin
        MemtoReg = 1'b1;
        reg_we   = 1'b1;
      end
      S_MEM_WRITE: begin
        IorD   = 1'b1;
        mem_we = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA    = 1'b1;
        ALUOp      = 2'b01;
        PCSource   = 2'b01;
        pc_cond_we = 1'b1;
        BranchNe   = (op_code == OP_BNE);
      end
      S_JUMP: begin
        PCSource = 2'b10;
        pc_we    = 1'b1;
      end
      S_IMM_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b11;
        // Logical immediates are zero-extended, arithmetic ones sign-extended.
        ALUSrcB = ((op_code == OP_ANDI) || (op_code == OP_ORI)) ? 3'b100 : 3'b010;
      end
      S_IMM_WB: begin
        reg_we = 1'b1;
      end
      S_ILLEGAL: begin
        illegal = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Enables are masked by rst directly so nothing writes while reset is held,
  // even though FETCH with MEM_WAIT=1 would otherwise raise IRWrite/PCWrite.
  always_comb begin
    IRWrite     = ir_we      & ~rst;
    PCWrite     = pc_we      & ~rst;
    PCWriteCond = pc_cond_we & ~rst;
    MemWrite    = mem_we     & ~rst;
    RegWrite    = reg_we     & ~rst;
    illegal_op  = illegal    & ~rst;
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm. Three instances with MEM_WAIT = 1, 2 and 3
// share one clock. Each instance has its own rst and op_code. Expected outputs
// come from a cycle-index model: for each opcode class and MEM_WAIT it gives
// what the control word must be on cycle k of the instruction.

module tb_multicycle_control_fsm;

  logic             clk;
  logic [2:0]       rst_v;
  logic [2:0][5:0]  op_v;
  logic [2:0][17:0] ov;
  logic [2:0][3:0]  st;
  logic [2:0][3:0]  fetch_code;

  int nvec  = 0;
  int nfail = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    logic       IorD, ALUSrcA, RegDst, MemtoReg, IRWrite, PCWrite, PCWriteCond;
    logic       MemWrite, RegWrite, BranchNe, illegal_op;
    logic [2:0] ALUSrcB;
    logic [1:0] ALUOp, PCSource;
    logic [3:0] state_o;

    multicycle_control_fsm #(.MEM_WAIT(g + 1), .OPW(6)) u_dut (
      .clk(clk), .rst(rst_v[g]), .op_code(op_v[g]),
      .IorD(IorD), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
      .PCSource(PCSource), .RegDst(RegDst), .MemtoReg(MemtoReg),
      .IRWrite(IRWrite), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond),
      .MemWrite(MemWrite), .RegWrite(RegWrite), .BranchNe(BranchNe),
      .illegal_op(illegal_op), .state_o(state_o)
    );

    assign ov[g] = {IorD, ALUSrcA, ALUSrcB, ALUOp, PCSource, RegDst, MemtoReg,
                    IRWrite, PCWrite, PCWriteCond, MemWrite, RegWrite, BranchNe, illegal_op};
    assign st[g] = state_o;
  end

  // ---------------- reference model ----------------
  localparam int C_R = 0, C_LW = 1, C_SW = 2, C_BR = 3, C_J = 4, C_IMM = 5, C_ILL = 6;

  function automatic int op_class(input logic [5:0] op);
    case (op)
      6'd0:                    return C_R;
      6'd35:                   return C_LW;
      6'd43:                   return C_SW;
      6'd4, 6'd5:              return C_BR;
      6'd2:                    return C_J;
      6'd8, 6'd12, 6'd13, 6'd10: return C_IMM;
      default:                 return C_ILL;
    endcase
  endfunction

  // Cycles until the next FETCH; for an illegal op, cycles up to entering ILLEGAL.
  function automatic int latency(input logic [5:0] op, input int w);
    case (op_class(op))
      C_R, C_IMM: return w + 3;
      C_LW:       return 2 * w + 3;
      C_SW:       return 2 * w + 2;
      C_BR, C_J:  return w + 2;
      default:    return w + 1;
    endcase
  endfunction

  function automatic logic [17:0] pack(
    input logic iord, input logic srca, input logic [2:0] srcb, input logic [1:0] aluop,
    input logic [1:0] pcs, input logic rdst, input logic m2r, input logic irw,
    input logic pcw, input logic pcwc, input logic memw, input logic regw,
    input logic bne, input logic ill);
    return {iord, srca, srcb, aluop, pcs, rdst, m2r, irw, pcw, pcwc, memw, regw, bne, ill};
  endfunction

  function automatic logic [17:0] reset_word();
    return pack(0, 0, 3'b001, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  function automatic logic [17:0] illegal_word();
    return pack(0, 0, 3'b000, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 1);
  endfunction

  // Expected control word on cycle k (0-based) of an instruction, memory wait w.
  function automatic logic [17:0] model(input logic [5:0] op, input int w, input int k);
    int j;
    if (k < w) begin
      logic last;
      last = (k == w - 1);
      return pack(0, 0, 3'b001, 2'b00, 2'b00, 0, 0, last, last, 0, 0, 0, 0, 0);
    end
    if (k == w) return pack(0, 0, 3'b011, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    j = k - w - 1;
    case (op_class(op))
      C_R:
        if (j == 0) return pack(0, 1, 3'b000, 2'b10, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        else        return pack(0, 0, 3'b000, 2'b00, 2'b00, 1, 0, 0, 0, 0, 0, 1, 0, 0);
      C_IMM:
        if (j == 0) return pack(0, 1, (op == 6'd12 || op == 6'd13) ? 3'b100 : 3'b010,
                                2'b11, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        else        return pack(0, 0, 3'b000, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      C_LW:
        if (j == 0)      return pack(0, 1, 3'b010, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        else if (j <= w) return pack(1, 0, 3'b000, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        else             return pack(0, 0, 3'b000, 2'b00, 2'b00, 0, 1, 0, 0, 0, 0, 1, 0, 0);
      C_SW:
        if (j == 0) return pack(0, 1, 3'b010, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        else        return pack(1, 0, 3'b000, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1, 0, 0, 0);
      C_BR:
        return pack(0, 1, 3'b000, 2'b01, 2'b01, 0, 0, 0, 0, 1, 0, 0, op == 6'd5, 0);
      C_J:
        return pack(0, 0, 3'b000, 2'b00, 2'b10, 0, 0, 0, 1, 0, 0, 0, 0, 0);
      default:
        return illegal_word();
    endcase
  endfunction

  // ---------------- checking helpers ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Release dut g from reset (others held in reset) and step one instruction.
  // Illegal opcodes are followed by a 20-cycle hold check and a reset pulse.
  task automatic run_instr(input int g, input logic [5:0] op);
    int w, len;
    logic [3:0] ill_code;
    w = g + 1;
    len = latency(op, w);
    for (int d = 0; d < 3; d++) if (d != g) rst_v[d] = 1'b1;
    op_v[g] = op;
    if (rst_v[g]) begin
      rst_v[g] = 1'b0;
    end
    #1;
    for (int k = 0; k < len; k++) begin
      chk($sformatf("dut%0d op%02h k%0d", g, op, k), 32'(ov[g]), 32'(model(op, w, k)));
      if (k == 0) chk($sformatf("dut%0d fetch state", g), 32'(st[g]), 32'(fetch_code[g]));
      @(negedge clk);
    end
    if (op_class(op) == C_ILL) begin
      ill_code = st[g];
      for (int c = 0; c < 20; c++) begin
        chk($sformatf("dut%0d illegal hold %0d", g, c), 32'(ov[g]), 32'(illegal_word()));
        chk($sformatf("dut%0d illegal state %0d", g, c), 32'(st[g]), 32'(ill_code));
        @(negedge clk);
      end
      rst_v[g] = 1'b1;
      #1;
      chk($sformatf("dut%0d illegal reset word", g), 32'(ov[g]), 32'(reset_word()));
      chk($sformatf("dut%0d illegal reset state", g), 32'(st[g]), 32'(fetch_code[g]));
      @(negedge clk);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [5:0] legal [10];
    logic [5:0] op;
    int g;
    legal = '{6'd0, 6'd35, 6'd43, 6'd4, 6'd5, 6'd2, 6'd8, 6'd12, 6'd13, 6'd10};

    rst_v = 3'b111;
    op_v  = '0;
    repeat (2) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      fetch_code[d] = st[d];
      chk($sformatf("dut%0d reset word", d), 32'(ov[d]), 32'(reset_word()));
    end

    // Directed: R-type W=1, lw W=3, sw W=2, branches and immediates, illegal.
    run_instr(0, 6'b000000);
    run_instr(0, 6'b000000);
    run_instr(2, 6'b100011);
    run_instr(1, 6'b101011);
    run_instr(1, 6'b000101);
    run_instr(1, 6'b000100);
    run_instr(1, 6'b001101);
    run_instr(1, 6'b001000);
    run_instr(0, 6'b111111);
    run_instr(0, 6'b000010);

    // Reset during cycle 2 of the 3-cycle MEM_WRITE window (W=3, sw).
    rst_v[0] = 1'b1; rst_v[1] = 1'b1;
    op_v[2] = 6'b101011;
    rst_v[2] = 1'b0;
    #1;
    for (int k = 0; k < 7; k++) begin
      chk($sformatf("abort sw k%0d", k), 32'(ov[2]), 32'(model(6'b101011, 3, k)));
      if (k < 6) @(negedge clk);
    end
    #1 rst_v[2] = 1'b1;
    #1;
    chk("abort MemWrite drop", 32'(g_dut[2].MemWrite), 32'(0));
    chk("abort reset word", 32'(ov[2]), 32'(reset_word()));
    chk("abort state fetch", 32'(st[2]), 32'(fetch_code[2]));
    @(negedge clk);
    run_instr(2, 6'b100011);
    run_instr(2, 6'b000000);

    // Randomized instruction stream across the three memory latencies.
    for (int n = 0; n < 60; n++) begin
      g = $urandom_range(0, 2);
      if ($urandom_range(0, 11) == 0) op = 6'($urandom_range(0, 63));
      else                            op = legal[$urandom_range(0, 9)];
      run_instr(g, op);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
